// File: rtl/flags_if.sv
// Signal bundle between the flags controller and its environment: ALU updates,
// interrupt save/restore requests, branch condition queries and register write-back.
interface flags_if;
    logic       alu_valid;
    logic [4:0] alu_mask;
    logic [4:0] flags_alu;
    logic [4:0] flags_cur;
    logic       push_req;
    logic       pop_req;
    logic       cond_req;
    logic [3:0] cond_code;
    logic       ceFlags;
    logic [4:0] flags_wr;
    logic       cond_valid;
    logic       cond_true;
    logic       stack_full;
    logic       stack_empty;
    logic       err_ovf;
    logic       err_unf;

    modport master (
        output alu_valid, alu_mask, flags_alu, flags_cur,
        output push_req, pop_req, cond_req, cond_code,
        input  ceFlags, flags_wr, cond_valid, cond_true,
        input  stack_full, stack_empty, err_ovf, err_unf
    );

    modport slave (
        input  alu_valid, alu_mask, flags_alu, flags_cur,
        input  push_req, pop_req, cond_req, cond_code,
        output ceFlags, flags_wr, cond_valid, cond_true,
        output stack_full, stack_empty, err_ovf, err_unf
    );
endinterface

// File: rtl/flags_ctrl.sv
// Flags register controller: merges masked ALU updates, saves/restores flags on a
// small LIFO for interrupts, and evaluates branch conditions with write forwarding.
module flags_ctrl #(
    parameter int STACK_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    flags_if.slave bus
);
    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;

    logic           ce_reg, ce_next;
    logic [4:0]     wr_reg, wr_next;
    logic [SPW-1:0] sp_reg, sp_next;
    logic           ovf_reg, unf_reg, cv_reg;
    logic [3:0]     code_reg;
    logic [4:0]     stack_mem [STACK_DEPTH];

    logic [4:0]     eff, merged, stack_top;
    logic [AW-1:0]  top_idx;
    logic           full, empty, push_only, pop_only, push_ok, cond_hit;

    // A write still in flight is newer than the register outputs.
    assign eff = ce_reg ? wr_reg : bus.flags_cur;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_merge
            assign merged[gi] = bus.alu_mask[gi] ? bus.flags_alu[gi] : eff[gi];
        end
    endgenerate

    assign full      = (sp_reg == SPW'(STACK_DEPTH));
    assign empty     = (sp_reg == '0);
    assign push_only = bus.push_req & ~bus.pop_req;
    assign pop_only  = bus.pop_req & ~bus.push_req;
    assign push_ok   = push_only & ~full;
    assign top_idx   = sp_reg[AW-1:0] - AW'(1);
    assign stack_top = stack_mem[top_idx];

    always_comb begin
        ce_next = 1'b0;
        wr_next = wr_reg;
        sp_next = sp_reg;
        // A pop request suppresses the ALU update even when the stack is empty.
        if (pop_only) begin
            if (!empty) begin
                wr_next = stack_top;
                ce_next = 1'b1;
                sp_next = sp_reg - SPW'(1);
            end
        end else if (bus.alu_valid) begin
            wr_next = merged;
            ce_next = 1'b1;
        end
        if (push_ok) begin
            sp_next = sp_reg + SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_reg  <= 1'b0;
            wr_reg  <= '0;
            sp_reg  <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
            cv_reg  <= 1'b0;
        end else begin
            ce_reg <= ce_next;
            wr_reg <= wr_next;
            sp_reg <= sp_next;
            cv_reg <= bus.cond_req;
            if (push_only && full) ovf_reg <= 1'b1;
            if (pop_only && empty) unf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.cond_req) code_reg <= bus.cond_code;
    end

    // Saved words carry the pre-update eff, so a same-cycle ALU write is not captured.
    always_ff @(posedge clk) begin
        if (push_ok) stack_mem[sp_reg[AW-1:0]] <= eff;
    end

    always_comb begin
        cond_hit = 1'b0;
        case (code_reg)
            4'd0:  cond_hit = 1'b1;
            4'd1:  cond_hit = eff[1];
            4'd2:  cond_hit = ~eff[1];
            4'd3:  cond_hit = eff[0];
            4'd4:  cond_hit = ~eff[0];
            4'd5:  cond_hit = eff[2];
            4'd6:  cond_hit = ~eff[2];
            4'd7:  cond_hit = eff[3];
            4'd8:  cond_hit = ~eff[3];
            4'd9:  cond_hit = eff[4];
            4'd10: cond_hit = ~eff[4];
            4'd11: cond_hit = eff[2] ^ eff[3];
            4'd12: cond_hit = ~(eff[2] ^ eff[3]);
            4'd13: cond_hit = ~eff[1] & ~(eff[2] ^ eff[3]);
            4'd14: cond_hit = eff[1] | (eff[2] ^ eff[3]);
            default: cond_hit = 1'b0;
        endcase
    end

    assign bus.ceFlags     = ce_reg;
    assign bus.flags_wr    = wr_reg;
    assign bus.cond_valid  = cv_reg;
    assign bus.cond_true   = cv_reg & cond_hit;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.err_ovf     = ovf_reg;
    assign bus.err_unf     = unf_reg;
endmodule
